// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MIPS memory stage: access sizes, write-back control
// bit positions and the byte-lane enable decode used by stores.
package mem_stage_pkg;

  localparam logic [1:0] LS_WORD  = 2'b00;
  localparam logic [1:0] LS_BYTE  = 2'b01;
  localparam logic [1:0] LS_HALF  = 2'b10;
  localparam logic [1:0] LS_BYTEU = 2'b11;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Halfword stores ignore lane[0] so they always land on an aligned pair.
  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      LS_WORD: be = 4'b1111;
      LS_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b0001 << lane;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Word-organised data RAM: synchronous byte-enable write, asynchronous read.
module data_mem #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data memory access with sub-word loads/stores, branch resolution
// and the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  WBM,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic        Branch,
  input  logic [1:0]  lbSel,
  input  logic        zeroM,
  input  logic [31:0] PCAdderM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] ReadData2M,
  input  logic [4:0]  RegDstM,
  output logic        PCSrcM,
  output logic [31:0] PCBranchM,
  output logic [1:0]  WBW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUResultW,
  output logic [4:0]  RegDstW
);

  logic [ADDR_W-1:0] wordAddr;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [31:0]       shifted;
  logic [15:0]       selHalf;
  logic [31:0]       loadVal;

  assign PCSrcM    = Branch & zeroM;
  assign PCBranchM = PCAdderM;

  assign wordAddr = ALUResultM[ADDR_W+1:2];
  assign lane     = ALUResultM[1:0];

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    be = byteEnable(lbSel, lane);
    case (lbSel)
      LS_WORD: wdata = ReadData2M;
      LS_HALF: wdata = {2{ReadData2M[15:0]}};
      default: wdata = {4{ReadData2M[7:0]}};
    endcase
  end

  data_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) uDataMem (
    .clk  (clk),
    .we   (MemWrite & ~rst),
    .be   (be),
    .addr (wordAddr),
    .wdata(wdata),
    .rdata(rdata)
  );

  assign shifted = rdata >> {lane, 3'b000};
  assign selHalf = lane[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    loadVal = '0;
    if (MemRead) begin
      case (lbSel)
        LS_WORD:  loadVal = rdata;
        LS_BYTE:  loadVal = {{24{shifted[7]}}, shifted[7:0]};
        LS_HALF:  loadVal = {{16{selHalf[15]}}, selHalf};
        LS_BYTEU: loadVal = {24'd0, shifted[7:0]};
        default:  loadVal = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WBW        <= '0;
      ReadDataW  <= '0;
      ALUResultW <= '0;
      RegDstW    <= '0;
    end else begin
      WBW        <= {WBM[WB_REGWRITE], WBM[WB_MEMTOREG]};
      ReadDataW  <= loadVal;
      ALUResultW <= ALUResultM;
      RegDstW    <= RegDstM;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed vectors push expected MEM/WB
// contents, a monitor pops and compares them one cycle later.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  WBM;
  logic        MemWrite, MemRead, Branch, zeroM;
  logic [1:0]  lbSel;
  logic [31:0] PCAdderM, ALUResultM, ReadData2M;
  logic [4:0]  RegDstM;
  logic        PCSrcM;
  logic [31:0] PCBranchM;
  logic [1:0]  WBW;
  logic [31:0] ReadDataW, ALUResultW;
  logic [4:0]  RegDstW;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] readData;
    logic [31:0] alu;
    logic [4:0]  regDst;
  } wbExp_t;

  wbExp_t expQ[$];
  string  nameQ[$];
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk       (clk),
    .rst       (rst),
    .WBM       (WBM),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Branch    (Branch),
    .lbSel     (lbSel),
    .zeroM     (zeroM),
    .PCAdderM  (PCAdderM),
    .ALUResultM(ALUResultM),
    .ReadData2M(ReadData2M),
    .RegDstM   (RegDstM),
    .PCSrcM    (PCSrcM),
    .PCBranchM (PCBranchM),
    .WBW       (WBW),
    .ReadDataW (ReadDataW),
    .ALUResultW(ALUResultW),
    .RegDstW   (RegDstW)
  );

  // Drive one EX/MEM entry at the falling edge; the expected MEM/WB entry is queued
  // and the combinational branch outputs are checked straight away.
  task automatic applyStimulus(input string name, input logic r, input logic [1:0] wbm,
                               input logic wr, input logic rd, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [4:0] dst, input logic [31:0] expRead,
                               input logic br = 1'b0, input logic zf = 1'b0,
                               input logic [31:0] pc = 32'h0);
    wbExp_t e;
    @(negedge clk);
    rst = r; WBM = wbm; MemWrite = wr; MemRead = rd; lbSel = size;
    ALUResultM = addr; ReadData2M = data; RegDstM = dst;
    Branch = br; zeroM = zf; PCAdderM = pc;
    e = r ? '0 : wbExp_t'{wb: wbm, readData: expRead, alu: addr, regDst: dst};
    expQ.push_back(e);
    nameQ.push_back(name);
    #1;
    checks++;
    if (PCSrcM !== (br & zf) || PCBranchM !== pc) begin
      errors++;
      $display("[TB] FAIL %s branch: got PCSrcM=%b PCBranchM=%h, want %b %h",
               name, PCSrcM, PCBranchM, br & zf, pc);
    end
  endtask

  task automatic checkOutput(input string name, input wbExp_t e);
    checks++;
    if ({WBW, ReadDataW, ALUResultW, RegDstW} !== e) begin
      errors++;
      $display("[TB] FAIL %s: got WB=%b RD=%h ALU=%h DST=%0d, want WB=%b RD=%h ALU=%h DST=%0d",
               name, WBW, ReadDataW, ALUResultW, RegDstW, e.wb, e.readData, e.alu, e.regDst);
    end
  endtask

  // Monitor: every MEM/WB update is compared against the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) checkOutput(nameQ.pop_front(), expQ.pop_front());
    end
  end

  initial begin
    rst = 1'b1; WBM = '0; MemWrite = 0; MemRead = 0; Branch = 0; zeroM = 0;
    lbSel = '0; PCAdderM = '0; ALUResultM = '0; ReadData2M = '0; RegDstM = '0;

    applyStimulus("reset0", 1, 2'b11, 0, 0, 2'b00, 32'h0,  32'h0, 5'd1, 32'h0);
    applyStimulus("reset1", 1, 2'b10, 0, 0, 2'b00, 32'h4,  32'h0, 5'd2, 32'h0);

    applyStimulus("sw10",   0, 2'b00, 1, 0, 2'b00, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0);
    applyStimulus("lw10",   0, 2'b11, 0, 1, 2'b00, 32'h10, 32'h0, 5'd5, 32'hDEADBEEF);

    applyStimulus("sw20",   0, 2'b00, 1, 0, 2'b00, 32'h20, 32'h8091A2B3, 5'd0, 32'h0);
    applyStimulus("lb21",   0, 2'b11, 0, 1, 2'b01, 32'h21, 32'h0, 5'd6, 32'hFFFFFFA2);
    applyStimulus("lbu21",  0, 2'b11, 0, 1, 2'b11, 32'h21, 32'h0, 5'd7, 32'h000000A2);
    applyStimulus("lh22",   0, 2'b11, 0, 1, 2'b10, 32'h22, 32'h0, 5'd8, 32'hFFFF8091);
    applyStimulus("lh23",   0, 2'b11, 0, 1, 2'b10, 32'h23, 32'h0, 5'd9, 32'hFFFF8091);
    applyStimulus("lh20",   0, 2'b11, 0, 1, 2'b10, 32'h20, 32'h0, 5'd10, 32'hFFFFA2B3);
    applyStimulus("lbu23",  0, 2'b11, 0, 1, 2'b11, 32'h23, 32'h0, 5'd11, 32'h00000080);
    applyStimulus("lb20",   0, 2'b11, 0, 1, 2'b01, 32'h20, 32'h0, 5'd12, 32'hFFFFFFB3);

    applyStimulus("sw30",   0, 2'b00, 1, 0, 2'b00, 32'h30, 32'h00000000, 5'd0, 32'h0);
    applyStimulus("sb32",   0, 2'b00, 1, 0, 2'b01, 32'h32, 32'hAAAAAA55, 5'd0, 32'h0);
    applyStimulus("sh30",   0, 2'b00, 1, 0, 2'b10, 32'h30, 32'hFFFF1234, 5'd0, 32'h0);
    applyStimulus("lw30a",  0, 2'b11, 0, 1, 2'b00, 32'h30, 32'h0, 5'd13, 32'h00551234);
    applyStimulus("sh33",   0, 2'b00, 1, 0, 2'b10, 32'h33, 32'h00005678, 5'd0, 32'h0);
    applyStimulus("lw30b",  0, 2'b11, 0, 1, 2'b00, 32'h30, 32'h0, 5'd14, 32'h56781234);

    applyStimulus("sw40",   0, 2'b00, 1, 0, 2'b00, 32'h40, 32'h00000001, 5'd0, 32'h0);
    applyStimulus("rbw40",  0, 2'b11, 1, 1, 2'b00, 32'h40, 32'h00000002, 5'd15, 32'h00000001);
    applyStimulus("lw40",   0, 2'b11, 0, 1, 2'b00, 32'h40, 32'h0, 5'd16, 32'h00000002);

    applyStimulus("brTaken", 0, 2'b00, 0, 0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1, 1, 32'h100);
    applyStimulus("brNotZ",  0, 2'b00, 0, 0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1, 0, 32'h100);
    applyStimulus("brNone",  0, 2'b00, 0, 0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 0, 1, 32'h200);

    applyStimulus("sw50",   0, 2'b00, 1, 0, 2'b00, 32'h50, 32'h11223344, 5'd0, 32'h0);
    applyStimulus("rstWr",  1, 2'b11, 1, 1, 2'b00, 32'h50, 32'hFFFFFFFF, 5'd17, 32'h0, 1, 1, 32'h300);
    applyStimulus("lw50",   0, 2'b11, 0, 1, 2'b00, 32'h50, 32'h0, 5'd18, 32'h11223344);
    applyStimulus("lw10b",  0, 2'b11, 0, 1, 2'b00, 32'h10, 32'h0, 5'd19, 32'hDEADBEEF);
    applyStimulus("lwWrap", 0, 2'b01, 0, 1, 2'b00, 32'h450, 32'h0, 5'd20, 32'h11223344);
    applyStimulus("noRead", 0, 2'b10, 0, 0, 2'b00, 32'h20, 32'h0, 5'd21, 32'h0);

    @(negedge clk);
    MemWrite = 0; MemRead = 0; rst = 0;
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending entries, want 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
